// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with hold, bubble, flush,
// optional one-entry skid buffer and saturating perf counters.
//
// Ports:
//   clock, reset      : posedge clock, synchronous active-high reset
//   x_ctrl, x_data    : control vector and payload from producer stage x
//   x_stall           : producer output this cycle is a bubble
//   m_stall           : consumer stage m stalled, hold contents
//   m_flush           : kill contents (mispredict / exception)
//   x_ready           : stage accepts x output this cycle
//   m_ctrl, m_data    : registered control vector and payload
//   m_valid           : main register holds a non-bubble entry
//   skid_full         : skid entry occupied (0 when SKID=0)
//   stall_cycles      : saturating count of stalled valid cycles
//   bubble_cycles     : saturating count of bubbles captured
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 32,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CTRL_W-1:0] x_ctrl,
  input  logic [DATA_W-1:0] x_data,
  input  logic              x_stall,
  input  logic              m_stall,
  input  logic              m_flush,
  output logic              x_ready,
  output logic [CTRL_W-1:0] m_ctrl,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              skid_full,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  bubble_cycles
);

  localparam logic SKID_EN = (SKID != 0);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] sk_ctrl_q, sk_ctrl_d;
  logic [DATA_W-1:0] sk_data_q, sk_data_d;
  logic              sk_full_q, sk_full_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  bub_q, bub_d;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + ONE;
  endfunction

  always_comb begin
    ctrl_d    = ctrl_q;
    data_d    = data_q;
    valid_d   = valid_q;
    sk_ctrl_d = sk_ctrl_q;
    sk_data_d = sk_data_q;
    sk_full_d = sk_full_q;
    stall_d   = stall_q;
    bub_d     = bub_q;
    if (m_flush) begin
      // payload is left alone; only the control side is killed
      ctrl_d    = '0;
      valid_d   = 1'b0;
      sk_full_d = 1'b0;
    end else if (m_stall) begin
      if (valid_q) begin
        stall_d = sat_inc(stall_q);
      end
      // park a real entry; a bubble is simply dropped
      if (SKID_EN && !sk_full_q && !x_stall) begin
        sk_ctrl_d = x_ctrl;
        sk_data_d = x_data;
        sk_full_d = 1'b1;
      end
    end else if (sk_full_q) begin
      // drain skid first; x was held off by x_ready=0
      ctrl_d    = sk_ctrl_q;
      data_d    = sk_data_q;
      valid_d   = 1'b1;
      sk_full_d = 1'b0;
    end else begin
      data_d = x_data;
      if (x_stall) begin
        ctrl_d  = '0;
        valid_d = 1'b0;
        bub_d   = sat_inc(bub_q);
      end else begin
        ctrl_d  = x_ctrl;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sk_ctrl_q <= '0;
      sk_data_q <= '0;
      sk_full_q <= 1'b0;
      stall_q   <= '0;
      bub_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sk_ctrl_q <= sk_ctrl_d;
      sk_data_q <= sk_data_d;
      sk_full_q <= sk_full_d;
      stall_q   <= stall_d;
      bub_q     <= bub_d;
    end
  end

  // with a skid, ready is registered and independent of m_stall
  assign x_ready       = SKID_EN ? ~sk_full_q : ~m_stall;
  assign m_ctrl        = ctrl_q;
  assign m_data        = data_q;
  assign m_valid       = valid_q;
  assign skid_full     = sk_full_q;
  assign stall_cycles  = stall_q;
  assign bubble_cycles = bub_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: three instances
// (plain, skid, 2-bit counters) driven by directed vectors.
module tb_pipe_stage_reg;

  typedef struct {
    int          cyc;
    int          d;
    logic [3:0]  c;
    logic [31:0] dt;
    logic        v;
    logic        f;
    logic        r;
    logic [15:0] s;
    logic [15:0] b;
    string       nm;
  } exp_t;

  logic        clock;
  logic        rs [3];
  logic [3:0]  xc [3];
  logic [31:0] xd [3];
  logic        xs [3];
  logic        ms [3];
  logic        fl [3];
  logic        xr [3];
  logic [3:0]  mc [3];
  logic [31:0] md [3];
  logic        mv [3];
  logic        sf [3];
  logic [15:0] sc0, bc0, sc1, bc1;
  logic [1:0]  sc2, bc2;

  exp_t sb[$];
  exp_t e;
  exp_t a;
  int   cyc;
  int   n_vec;
  int   n_err;

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .SKID(0), .CNT_W(16)) u0 (
    .clock(clock), .reset(rs[0]), .x_ctrl(xc[0]), .x_data(xd[0]),
    .x_stall(xs[0]), .m_stall(ms[0]), .m_flush(fl[0]),
    .x_ready(xr[0]), .m_ctrl(mc[0]), .m_data(md[0]),
    .m_valid(mv[0]), .skid_full(sf[0]),
    .stall_cycles(sc0), .bubble_cycles(bc0)
  );

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .SKID(1), .CNT_W(16)) u1 (
    .clock(clock), .reset(rs[1]), .x_ctrl(xc[1]), .x_data(xd[1]),
    .x_stall(xs[1]), .m_stall(ms[1]), .m_flush(fl[1]),
    .x_ready(xr[1]), .m_ctrl(mc[1]), .m_data(md[1]),
    .m_valid(mv[1]), .skid_full(sf[1]),
    .stall_cycles(sc1), .bubble_cycles(bc1)
  );

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .SKID(0), .CNT_W(2)) u2 (
    .clock(clock), .reset(rs[2]), .x_ctrl(xc[2]), .x_data(xd[2]),
    .x_stall(xs[2]), .m_stall(ms[2]), .m_flush(fl[2]),
    .x_ready(xr[2]), .m_ctrl(mc[2]), .m_data(md[2]),
    .m_valid(mv[2]), .skid_full(sf[2]),
    .stall_cycles(sc2), .bubble_cycles(bc2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // monitor: 1 time unit after each posedge, check due entries
  always @(posedge clock) begin
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.cyc < cyc) begin
        n_err++;
        $display("FAIL %s: stale, due cycle %0d, now %0d",
                 e.nm, e.cyc, cyc);
      end else begin
        a = e;
        a.c  = mc[e.d];
        a.dt = md[e.d];
        a.v  = mv[e.d];
        a.f  = sf[e.d];
        a.r  = xr[e.d];
        case (e.d)
          0: begin a.s = sc0; a.b = bc0; end
          1: begin a.s = sc1; a.b = bc1; end
          default: begin
            a.s = {14'd0, sc2};
            a.b = {14'd0, bc2};
          end
        endcase
        if (a.c !== e.c || a.dt !== e.dt || a.v !== e.v ||
            a.f !== e.f || a.r !== e.r || a.s !== e.s ||
            a.b !== e.b) begin
          n_err++;
          $display({"FAIL %s: got ctrl=%h data=%h v=%b skid=%b ",
                    "rdy=%b st=%0d bb=%0d, want ctrl=%h data=%h ",
                    "v=%b skid=%b rdy=%b st=%0d bb=%0d"},
                   e.nm, a.c, a.dt, a.v, a.f, a.r, a.s, a.b,
                   e.c, e.dt, e.v, e.f, e.r, e.s, e.b);
        end
      end
    end
  end

  task automatic step(
    input int          d,
    input logic        r,
    input logic        x_s,
    input logic        m_s,
    input logic        f,
    input logic [3:0]  c,
    input logic [31:0] dt,
    input logic [3:0]  ec,
    input logic [31:0] ed,
    input logic        ev,
    input logic        ef,
    input logic        er,
    input logic [15:0] es,
    input logic [15:0] eb,
    input string       nm
  );
    exp_t x;
    rs[d] = r;
    xs[d] = x_s;
    ms[d] = m_s;
    fl[d] = f;
    xc[d] = c;
    xd[d] = dt;
    x.cyc = cyc + 1;
    x.d   = d;
    x.c   = ec;
    x.dt  = ed;
    x.v   = ev;
    x.f   = ef;
    x.r   = er;
    x.s   = es;
    x.b   = eb;
    x.nm  = nm;
    sb.push_back(x);
    @(posedge clock);
    #2;
  endtask

  initial begin
    cyc   = 0;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 3; i++) begin
      rs[i] = 1'b1;
      xs[i] = 1'b0;
      ms[i] = 1'b0;
      fl[i] = 1'b0;
      xc[i] = 4'h0;
      xd[i] = 32'h0;
    end

    // plain register
    step(0,1,0,0,0,4'h0,32'h0,
         4'h0,32'h0,0,0,1,0,0,"p_reset");
    step(0,0,0,0,0,4'hB,32'hDEADBEEF,
         4'hB,32'hDEADBEEF,1,0,1,0,0,"p_pass");
    step(0,0,0,0,0,4'h5,32'h11111111,
         4'h5,32'h11111111,1,0,1,0,0,"p_loadA");
    step(0,0,0,1,0,4'hF,32'h22222222,
         4'h5,32'h11111111,1,0,0,1,0,"p_hold1");
    step(0,0,0,1,0,4'hE,32'h33333333,
         4'h5,32'h11111111,1,0,0,2,0,"p_hold2");
    step(0,0,0,1,0,4'hD,32'h44444444,
         4'h5,32'h11111111,1,0,0,3,0,"p_hold3");
    step(0,0,1,0,0,4'hF,32'h55555555,
         4'h0,32'h55555555,0,0,1,3,1,"p_bubble");
    step(0,0,0,1,0,4'h1,32'h66666666,
         4'h0,32'h55555555,0,0,0,3,1,"p_stall_empty");
    step(0,0,0,0,0,4'h3,32'h77777777,
         4'h3,32'h77777777,1,0,1,3,1,"p_load");
    step(0,0,0,0,1,4'h9,32'h88888888,
         4'h0,32'h77777777,0,0,1,3,1,"p_flush");

    // skid buffer
    step(1,1,0,0,0,4'h0,32'h0,
         4'h0,32'h0,0,0,1,0,0,"s_reset");
    step(1,0,0,0,0,4'h5,32'hAAAA0000,
         4'h5,32'hAAAA0000,1,0,1,0,0,"s_loadA");
    step(1,0,0,1,0,4'h6,32'hBBBB0000,
         4'h5,32'hAAAA0000,1,1,0,1,0,"s_park");
    step(1,0,0,1,0,4'h7,32'hCCCC0000,
         4'h5,32'hAAAA0000,1,1,0,2,0,"s_both_hold");
    step(1,0,0,0,0,4'h7,32'hCCCC0000,
         4'h6,32'hBBBB0000,1,0,1,2,0,"s_drain");
    step(1,0,0,0,0,4'h7,32'hCCCC0000,
         4'h7,32'hCCCC0000,1,0,1,2,0,"s_loadC");
    step(1,0,1,1,0,4'h1,32'h0000000F,
         4'h7,32'hCCCC0000,1,0,1,3,0,"s_drop_bubble");
    step(1,0,0,1,0,4'h8,32'hDDDD0000,
         4'h7,32'hCCCC0000,1,1,0,4,0,"s_park2");
    step(1,0,0,1,1,4'h8,32'hDDDD0000,
         4'h0,32'hCCCC0000,0,0,1,4,0,"s_flush");
    step(1,0,0,0,0,4'h2,32'hEEEE0000,
         4'h2,32'hEEEE0000,1,0,1,4,0,"s_loadE");
    step(1,0,0,1,0,4'h3,32'hFFFF0000,
         4'h2,32'hEEEE0000,1,1,0,5,0,"s_park3");
    step(1,1,0,1,0,4'h3,32'hFFFF0000,
         4'h0,32'h0,0,0,1,0,0,"s_reset_full");
    step(1,0,0,0,0,4'h4,32'h12345678,
         4'h4,32'h12345678,1,0,1,0,0,"s_after_reset");
    step(1,0,1,0,0,4'hA,32'h99990000,
         4'h0,32'h99990000,0,0,1,0,1,"s_bubble");

    // 2-bit counters saturate
    step(2,1,0,0,0,4'h0,32'h0,
         4'h0,32'h0,0,0,1,0,0,"c_reset");
    step(2,0,0,0,0,4'h1,32'h1,
         4'h1,32'h1,1,0,1,0,0,"c_load");
    for (int i = 1; i <= 5; i++) begin
      step(2,0,0,1,0,4'h2,32'h2,
           4'h1,32'h1,1,0,0,16'((i > 3) ? 3 : i),0,"c_stall_sat");
    end
    for (int i = 1; i <= 4; i++) begin
      step(2,0,1,0,0,4'h3,32'(9 + i),
           4'h0,32'(9 + i),0,0,1,3,16'((i > 3) ? 3 : i),
           "c_bubble_sat");
    end
    step(2,0,0,1,0,4'h5,32'h14,
         4'h0,32'hD,0,0,0,3,3,"c_hold_sat");

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clock);
      #2;
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: never checked, due cycle %0d", e.nm, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
